seg7_scan_controller: RTL
=========================

// Module: seg7_scan_controller
// PURPOSE
// - Time-multiplexed scan sequencer for the 4-digit seven-segment display on the Basys3.
// - Generates the 2-bit select for the downstream 4-way nibble multiplexer and drives the
//   active-low anodes, with a blanking gap between digits to suppress ghosting.
// - Snapshots VALUE and DP_MASK once per frame so a displayed frame is never torn.
// - Sits between the value producers (e.g. the mouse driver) and the mux/segment decoder.
// PARAMETERS
// - DIGIT_PERIOD_CYC  100_000  clock cycles per digit slot (1 ms @ 100 MHz; frame = 4 slots)
// - BLANK_CYC         1_000    cycles at the start of each slot with all anodes off
// - Legal range: 1 <= BLANK_CYC < DIGIT_PERIOD_CYC; slot counter width = $clog2(DIGIT_PERIOD_CYC)
// PORTS
// - CLK          in   1   system clock, 100 MHz
// - RESETN       in   1   synchronous reset, active-low
// - ENABLE       in   1   1 = scan display; 0 = all digits dark
// - VALUE        in   16  four nibbles; VALUE[4i+3:4i] belongs to digit i
// - DP_MASK      in   4   decimal point request per digit, active-high
// - MUX_CONTROL  out  2   digit index; drives the 4-way mux select
// - SNAP_VALUE   out  16  frame-stable copy of VALUE; feeds the mux data inputs
// - ANODE_N      out  4   anode enables, active-low, one-hot-low or all ones
// - DP_N         out  1   decimal point, active-low
// - FRAME_DONE   out  1   one-cycle pulse when digit 3 slot completes
// BEHAVIOUR
// - One clock, CLK. Reset is synchronous and active-low on RESETN. All outputs are registered.
// - Reset (RESETN=0 at an edge): state=IDLE, MUX_CONTROL=0, SNAP_VALUE=0, snap DP=0,
//   ANODE_N=4'hF, DP_N=1, FRAME_DONE=0, slot counter=0. Reset wins over all other inputs.
// - States: IDLE, BLANK, SHOW.
// - IDLE: ANODE_N=F, DP_N=1. ENABLE=1 -> BLANK next edge, with digit=0, counter=0, and a
//   snapshot of VALUE and DP_MASK.
// - BLANK: ANODE_N=F, DP_N=1 for BLANK_CYC cycles (counter 0..BLANK_CYC-1), then SHOW.
// - SHOW: ANODE_N[digit]=0 (others 1), DP_N=~snapDP[digit], until counter=DIGIT_PERIOD_CYC-1.
//   Then counter=0, digit=digit+1 (mod 4), MUX_CONTROL updates, state=BLANK.
// - MUX_CONTROL changes only on entry to BLANK. The select is never switched while an anode is on.
// - Wrap 3->0: FRAME_DONE=1 for exactly that cycle. VALUE and DP_MASK are re-snapshotted on the
//   same edge. SNAP_VALUE is otherwise held; mid-frame input changes are ignored.
// - ENABLE=0 in BLANK/SHOW: next edge -> IDLE, ANODE_N=F, DP_N=1, no FRAME_DONE. MUX_CONTROL and
//   SNAP_VALUE hold. Re-enable always restarts at digit 0 with a fresh snapshot.
// - Latency: first lit anode BLANK_CYC+1 edges after ENABLE is sampled high.
// - Counter never exceeds DIGIT_PERIOD_CYC-1. Digit index is 2 bits and wraps naturally.
// - ANODE_N never has more than one zero bit in any cycle, including transitions.
// STRUCTURE
// - Package seg7_pkg: state enum (IDLE/BLANK/SHOW), ANODE_OFF=4'hF, digit index type (2 bits),
//   default timing constants.
// - Sub-module seg7_slot_timer: counter with terminal-count and blank-done flags. The FSM, digit
//   index, snapshot registers and output decode stay in the top.
// - The nibble mux and the segment decoder are external; they are not instantiated here.
// TESTING (bench params DIGIT_PERIOD_CYC=8, BLANK_CYC=2)
// - Reset: RESETN=0 for 5 cycles with ENABLE=1 -> ANODE_N=F, DP_N=1, MUX_CONTROL=0,
//   FRAME_DONE=0, SNAP_VALUE=0.
// - Scan: ENABLE=1, VALUE=16'h1234 -> per 8-cycle slot: 2 cycles ANODE_N=F, then 6 cycles of
//   1110/1101/1011/0111 with MUX_CONTROL 0/1/2/3. FRAME_DONE pulses once every 32 cycles.
// - Snapshot: VALUE changes to 16'hABCD during digit 1 -> SNAP_VALUE stays 16'h1234 until the
//   wrap edge, then becomes 16'hABCD together with FRAME_DONE.
// - Disable mid-SHOW of digit 2: ENABLE=0 -> ANODE_N=F next edge, MUX_CONTROL holds 2.
//   Re-enable -> BLANK, digit 0, first anode 1110 after 3 edges.
// - Decimal point: DP_MASK=4'b0100 -> DP_N=0 only during digit-2 SHOW cycles, 1 in all BLANK cycles.
// - Mid-operation reset: RESETN=0 for 1 cycle during SHOW -> all reset values at that edge; scan
//   resumes from digit 0 via IDLE->BLANK.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan controller.
// - Default slot timing for a 100 MHz clock (1 ms per digit, 10 us blank).
// - Scan state encoding, digit index type, anode constants and decode helper.
package seg7_pkg;

    localparam int DIGIT_PERIOD_DEF = 100_000;
    localparam int BLANK_DEF        = 1_000;

    localparam logic [3:0] ANODE_OFF = 4'hF;

    typedef logic [1:0] digit_t;
    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_BLANK = 2'd1;
    localparam state_t ST_SHOW  = 2'd2;

    // Active-low one-hot anode pattern for a digit index.
    function automatic logic [3:0] anode_sel(input digit_t d);
        return ~(4'b0001 << d);
    endfunction

endpackage

// File: rtl/seg7_slot_timer.sv
// Per-digit slot counter.
// - clk, resetn : clock, synchronous active-low reset
// - run         : count while high; counter is forced to 0 while low
// - blank_done  : counter is on the last blanking cycle of the slot
// - tc          : counter is on the last cycle of the slot (wraps to 0 next)
module seg7_slot_timer
    import seg7_pkg::*;
#(
    parameter int DIGIT_PERIOD_CYC = DIGIT_PERIOD_DEF,
    parameter int BLANK_CYC        = BLANK_DEF
) (
    input  logic clk,
    input  logic resetn,
    input  logic run,
    output logic blank_done,
    output logic tc
);

    localparam int CW = $clog2(DIGIT_PERIOD_CYC);
    localparam logic [CW-1:0] TC_VAL    = CW'(DIGIT_PERIOD_CYC - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (!resetn)
            count <= '0;
        else if (!run || tc)
            count <= '0;
        else
            count <= count + 1'b1;
    end

    assign blank_done = (count == BLANK_END);
    assign tc         = (count == TC_VAL);

endmodule

// File: rtl/seg7_scan_controller.sv
// Time-multiplexed scan sequencer for a 4-digit seven-segment display.
// - clk, resetn  : clock, synchronous active-low reset
// - enable       : 1 = scan, 0 = all digits dark
// - value        : four nibbles, value[4i+3:4i] is digit i
// - dp_mask      : decimal point request per digit, active-high
// - mux_control  : digit index for the external nibble mux
// - snap_value   : frame-stable copy of value for the mux data inputs
// - anode_n      : active-low anodes, at most one low at any time
// - dp_n         : active-low decimal point
// - frame_done   : one-cycle pulse when the digit-3 slot completes
// Each slot starts with a blank gap (all anodes off) before the digit is lit,
// so the mux select only ever moves while the display is dark.
module seg7_scan_controller
    import seg7_pkg::*;
#(
    parameter int DIGIT_PERIOD_CYC = DIGIT_PERIOD_DEF,
    parameter int BLANK_CYC        = BLANK_DEF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        enable,
    input  logic [15:0] value,
    input  logic [3:0]  dp_mask,
    output logic [1:0]  mux_control,
    output logic [15:0] snap_value,
    output logic [3:0]  anode_n,
    output logic        dp_n,
    output logic        frame_done
);

    state_t state, state_nx;
    digit_t digit_nx;
    logic [3:0] snap_dp;
    logic snap_ld, wrap;
    logic blank_done, tc;

    seg7_slot_timer #(
        .DIGIT_PERIOD_CYC (DIGIT_PERIOD_CYC),
        .BLANK_CYC        (BLANK_CYC)
    ) u_timer (
        .clk        (clk),
        .resetn     (resetn),
        .run        ((state != ST_IDLE) && enable),
        .blank_done (blank_done),
        .tc         (tc)
    );

    always_comb begin
        state_nx = state;
        digit_nx = mux_control;
        snap_ld  = 1'b0;
        wrap     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable) begin
                    state_nx = ST_BLANK;
                    digit_nx = '0;
                    snap_ld  = 1'b1;
                end
            end
            ST_BLANK: begin
                if (!enable)
                    state_nx = ST_IDLE;
                else if (blank_done)
                    state_nx = ST_SHOW;
            end
            ST_SHOW: begin
                if (!enable)
                    state_nx = ST_IDLE;
                else if (tc) begin
                    state_nx = ST_BLANK;
                    digit_nx = mux_control + 2'd1;
                    // Frame boundary: latch new display data on the 3->0 wrap.
                    if (mux_control == 2'd3) begin
                        wrap    = 1'b1;
                        snap_ld = 1'b1;
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Outputs are decoded from next-state so they are registered and change
    // on the same edge as the state they describe.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            mux_control <= '0;
            snap_value  <= '0;
            snap_dp     <= '0;
            anode_n     <= ANODE_OFF;
            dp_n        <= 1'b1;
            frame_done  <= 1'b0;
        end else begin
            state       <= state_nx;
            mux_control <= digit_nx;
            frame_done  <= wrap;
            if (snap_ld) begin
                snap_value <= value;
                snap_dp    <= dp_mask;
            end
            // SHOW is never entered on a snapshot edge, so snap_dp is current.
            if (state_nx == ST_SHOW) begin
                anode_n <= anode_sel(digit_nx);
                dp_n    <= ~snap_dp[digit_nx];
            end else begin
                anode_n <= ANODE_OFF;
                dp_n    <= 1'b1;
            end
        end
    end

endmodule
